// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: issues one imem request at a time and drives the PC's next address.
// It buffers responses into an IF/ID register with a valid/ready handshake, and redirects and flushes on taken branches.
module instr_fetch_stage #(
  parameter int XLEN   = 32,
  parameter int PC_INC = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_addr,
  output logic [XLEN-1:0] new_addr,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            id_ready
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic [1:0]      state, state_nxt;
  logic [XLEN-1:0] pend_instr, pend_pc;
  logic            out_free;
  logic            load_from_mem, load_from_pend, load_pend;
  logic            advance;

  assign out_free = !if_valid || id_ready;
  assign advance  = load_from_mem || load_from_pend;

  // Only one request is ever outstanding, so the request is simply "we are in S_REQ".
  assign imem_req  = rst_n && (state == S_REQ);
  assign imem_addr = pc_addr;

  always_comb begin
    if (br_taken)     new_addr = br_target;
    else if (advance) new_addr = pc_addr + XLEN'(PC_INC);
    else              new_addr = pc_addr;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt      = state;
    load_from_mem  = 1'b0;
    load_from_pend = 1'b0;
    load_pend      = 1'b0;
    case (state)
      S_REQ:  state_nxt = br_taken ? S_DROP : S_WAIT;
      S_WAIT: begin
        if (br_taken) begin
          state_nxt = imem_valid ? S_REQ : S_DROP;
        end else if (imem_valid) begin
          if (out_free) begin
            load_from_mem = 1'b1;
            state_nxt     = S_REQ;
          end else begin
            load_pend = 1'b1;
            state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (br_taken) begin
          state_nxt = S_REQ;
        end else if (id_ready) begin
          load_from_pend = 1'b1;
          state_nxt      = S_REQ;
        end
      end
      S_DROP:  if (imem_valid) state_nxt = S_REQ;
      default: state_nxt = S_REQ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_REQ;
      pend_instr <= '0;
      pend_pc    <= '0;
    end else begin
      state <= state_nxt;
      if (load_pend) begin
        pend_instr <= imem_rdata;
        pend_pc    <= pc_addr;
      end
    end
  end

  // Flush beats both a new capture and a plain decode transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else if (br_taken) begin
      if_valid <= 1'b0;
    end else if (load_from_mem) begin
      if_valid <= 1'b1;
      if_instr <= imem_rdata;
      if_pc    <= pc_addr;
    end else if (load_from_pend) begin
      if_valid <= 1'b1;
      if_instr <= pend_instr;
      if_pc    <= pend_pc;
    end else if (if_valid && id_ready) begin
      if_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Testbench for instr_fetch_stage: PC register and variable-latency memory models around the DUT.
// Directed scenarios plus a randomized run checked against a program-order delivery model.
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] pc_addr;
  logic [31:0] new_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  instr_fetch_stage #(.XLEN(32), .PC_INC(4)) dut (
    .clk(clk), .rst_n(rst_n), .pc_addr(pc_addr), .new_addr(new_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
    .imem_rdata(imem_rdata), .br_taken(br_taken), .br_target(br_target),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready)
  );

  // Program counter: loads new_addr every edge, with a bench-side preload.
  logic        pc_load = 1'b0;
  logic [31:0] pc_load_val = '0;
  always @(posedge clk) pc_addr <= pc_load ? pc_load_val : new_addr;

  // Instruction memory: the word at address a is a fixed scramble of a.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  int unsigned mem_lat_min = 1;
  int unsigned mem_lat_max = 1;
  logic        mem_busy;
  int unsigned mem_wait;
  logic [31:0] mem_raddr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_busy  <= 1'b0;
      mem_wait  <= 0;
      mem_raddr <= '0;
    end else if (imem_req === 1'b1) begin
      mem_busy  <= 1'b1;
      mem_wait  <= $urandom_range(mem_lat_max, mem_lat_min) - 1;
      mem_raddr <= imem_addr;
    end else if (mem_busy) begin
      if (mem_wait == 0) mem_busy <= 1'b0;
      else               mem_wait <= mem_wait - 1;
    end
  end

  assign imem_valid = mem_busy && (mem_wait == 0);
  assign imem_rdata = imem_valid ? mem_f(mem_raddr) : 32'hDEAD_BEEF;

  // Leaves the bench at a negedge right after reset release, PC = start.
  task automatic do_reset(input logic [31:0] start);
    @(negedge clk);
    rst_n = 1'b0; br_taken = 1'b0; br_target = '0; id_ready = 1'b0;
    pc_load = 1'b1; pc_load_val = start;
    repeat (2) @(negedge clk);
    pc_load = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; pc_load = 1'b1; pc_load_val = 32'h80;
    @(negedge clk);
    pc_load = 1'b0;
    @(negedge clk);
    #1;
    n_checks++; if (if_valid !== 1'b0) $display("FAIL reset_if_valid: got %0b want 0", if_valid); else n_pass++;
    n_checks++; if (if_instr !== 32'h0) $display("FAIL reset_if_instr: got %h want 0", if_instr); else n_pass++;
    n_checks++; if (if_pc !== 32'h0) $display("FAIL reset_if_pc: got %h want 0", if_pc); else n_pass++;
    n_checks++; if (imem_req !== 1'b0) $display("FAIL reset_imem_req: got %0b want 0", imem_req); else n_pass++;
    n_checks++; if (pc_addr !== 32'h80) $display("FAIL reset_pc_held: got %h want 00000080", pc_addr); else n_pass++;
    n_checks++; if (new_addr !== 32'h80) $display("FAIL reset_new_addr: got %h want 00000080", new_addr); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b1) $display("FAIL reset_first_req: got %0b want 1", imem_req); else n_pass++;
    n_checks++; if (imem_addr !== 32'h80) $display("FAIL reset_first_addr: got %h want 00000080", imem_addr); else n_pass++;
  endtask

  task automatic test_sequential();
    logic [31:0] req_q[$];
    logic [31:0] pc_q[$];
    logic [31:0] ins_q[$];
    int          n_cap;
    mem_lat_min = 1; mem_lat_max = 1;
    do_reset(32'h0);
    id_ready = 1'b1;
    n_cap = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (imem_req) req_q.push_back(imem_addr);
      if (imem_valid) begin
        n_cap++;
        n_checks++;
        if (new_addr !== 32'(4 * n_cap)) $display("FAIL seq_new_addr: got %h want %h", new_addr, 32'(4 * n_cap));
        else n_pass++;
      end
      if (if_valid && id_ready) begin
        pc_q.push_back(if_pc);
        ins_q.push_back(if_instr);
      end
      @(negedge clk);
    end
    n_checks++; if (req_q.size() < 3) $display("FAIL seq_req_count: got %0d want >=3", req_q.size()); else n_pass++;
    n_checks++; if (pc_q.size() < 3) $display("FAIL seq_deliver_count: got %0d want >=3", pc_q.size()); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      if (k < req_q.size()) begin
        n_checks++;
        if (req_q[k] !== 32'(4 * k)) $display("FAIL seq_req_addr[%0d]: got %h want %h", k, req_q[k], 32'(4 * k));
        else n_pass++;
      end
      if (k < pc_q.size()) begin
        n_checks++;
        if (pc_q[k] !== 32'(4 * k) || ins_q[k] !== mem_f(32'(4 * k)))
          $display("FAIL seq_deliver[%0d]: got pc %h instr %h want pc %h instr %h",
                   k, pc_q[k], ins_q[k], 32'(4 * k), mem_f(32'(4 * k)));
        else n_pass++;
      end
    end
    id_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    mem_lat_min = 1; mem_lat_max = 1;
    do_reset(32'h40);
    #1; @(negedge clk);
    #1;
    n_checks++; if (new_addr !== 32'h44) $display("FAIL bp_first_capture: got %h want 00000044", new_addr); else n_pass++;
    @(negedge clk); #1; @(negedge clk);
    #1;
    n_checks++; if (imem_valid !== 1'b1 || new_addr !== 32'h44)
      $display("FAIL bp_no_advance: got valid %0b new_addr %h want 1 00000044", imem_valid, new_addr); else n_pass++;
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++; if (imem_req !== 1'b0) $display("FAIL bp_hold_req: got %0b want 0", imem_req); else n_pass++;
      n_checks++; if (new_addr !== 32'h44) $display("FAIL bp_hold_new_addr: got %h want 00000044", new_addr); else n_pass++;
      n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== mem_f(32'h40))
        $display("FAIL bp_hold_ifid: got v %0b pc %h instr %h want 1 00000040 %h", if_valid, if_pc, if_instr, mem_f(32'h40));
      else n_pass++;
      @(negedge clk);
    end
    id_ready = 1'b1;
    #1;
    n_checks++; if (new_addr !== 32'h48) $display("FAIL bp_release_new_addr: got %h want 00000048", new_addr); else n_pass++;
    @(negedge clk);
    id_ready = 1'b0;
    #1;
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h44 || if_instr !== mem_f(32'h44))
      $display("FAIL bp_pending_moved: got v %0b pc %h instr %h want 1 00000044 %h", if_valid, if_pc, if_instr, mem_f(32'h44));
    else n_pass++;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h48)
      $display("FAIL bp_next_req: got req %0b addr %h want 1 00000048", imem_req, imem_addr); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_branch_wait();
    bit saw_late, got_req, got_cap;
    mem_lat_min = 1; mem_lat_max = 1;
    do_reset(32'h200);
    #1; @(negedge clk);
    #1; @(negedge clk);
    mem_lat_min = 3; mem_lat_max = 3;
    #1; @(negedge clk);
    br_taken = 1'b1; br_target = 32'h100;
    #1;
    n_checks++; if (new_addr !== 32'h100) $display("FAIL brw_new_addr: got %h want 00000100", new_addr); else n_pass++;
    @(negedge clk);
    br_taken = 1'b0;
    mem_lat_min = 1; mem_lat_max = 1;
    #1;
    n_checks++; if (if_valid !== 1'b0) $display("FAIL brw_flush: got %0b want 0", if_valid); else n_pass++;
    saw_late = 1'b0; got_req = 1'b0;
    for (int c = 0; c < 12 && !got_req; c++) begin
      if (imem_valid) saw_late = 1'b1;
      if (imem_req) begin
        got_req = 1'b1;
        n_checks++;
        if (imem_addr !== 32'h100 || !saw_late)
          $display("FAIL brw_redirect_req: got addr %h after_late %0b want 00000100 1", imem_addr, saw_late);
        else n_pass++;
      end
      @(negedge clk); #1;
    end
    if (!got_req) begin n_checks++; $display("FAIL brw_timeout: got no request want one within 12 cycles"); end
    got_cap = 1'b0;
    for (int c = 0; c < 6 && !got_cap; c++) begin
      if (if_valid) begin
        got_cap = 1'b1;
        n_checks++;
        if (if_pc !== 32'h100 || if_instr !== mem_f(32'h100))
          $display("FAIL brw_target_fetch: got pc %h instr %h want 00000100 %h", if_pc, if_instr, mem_f(32'h100));
        else n_pass++;
      end
      @(negedge clk); #1;
    end
    if (!got_cap) begin n_checks++; $display("FAIL brw_cap_timeout: got no capture want one within 6 cycles"); end
    @(negedge clk);
  endtask

  task automatic test_branch_coincident();
    mem_lat_min = 1; mem_lat_max = 1;
    do_reset(32'h300);
    id_ready = 1'b1;
    #1; @(negedge clk);
    br_taken = 1'b1; br_target = 32'h180;
    #1;
    n_checks++; if (imem_valid !== 1'b1 || new_addr !== 32'h180)
      $display("FAIL brc_new_addr: got valid %0b new_addr %h want 1 00000180", imem_valid, new_addr); else n_pass++;
    @(negedge clk);
    br_taken = 1'b0;
    #1;
    n_checks++; if (if_valid !== 1'b0) $display("FAIL brc_discard: got %0b want 0", if_valid); else n_pass++;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h180)
      $display("FAIL brc_next_req: got req %0b addr %h want 1 00000180", imem_req, imem_addr); else n_pass++;
    @(negedge clk);
    id_ready = 1'b0;
  endtask

  task automatic test_wrap();
    mem_lat_min = 1; mem_lat_max = 1;
    do_reset(32'hFFFF_FFFC);
    id_ready = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC)
      $display("FAIL wrap_req: got req %0b addr %h want 1 fffffffc", imem_req, imem_addr); else n_pass++;
    @(negedge clk);
    #1;
    n_checks++; if (new_addr !== 32'h0) $display("FAIL wrap_new_addr: got %h want 00000000", new_addr); else n_pass++;
    @(negedge clk);
    #1;
    n_checks++; if (if_pc !== 32'hFFFF_FFFC || if_instr !== mem_f(32'hFFFF_FFFC) || imem_addr !== 32'h0)
      $display("FAIL wrap_capture: got pc %h instr %h next %h want fffffffc %h 00000000",
               if_pc, if_instr, imem_addr, mem_f(32'hFFFF_FFFC));
    else n_pass++;
    @(negedge clk);
    id_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    mem_lat_min = 1; mem_lat_max = 1;
    do_reset(32'h500);
    repeat (4) begin #1; @(negedge clk); end
    #1;
    n_checks++; if (if_valid !== 1'b1 || imem_req !== 1'b0)
      $display("FAIL ar_in_hold: got v %0b req %0b want 1 0", if_valid, imem_req); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0)
      $display("FAIL ar_immediate: got v %0b req %0b want 0 0", if_valid, imem_req); else n_pass++;
    n_checks++; if (if_pc !== 32'h0 || if_instr !== 32'h0)
      $display("FAIL ar_ifid_cleared: got pc %h instr %h want 0 0", if_pc, if_instr); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if (pc_addr !== 32'h504 || new_addr !== 32'h504)
      $display("FAIL ar_pc_held: got pc %h new %h want 00000504 00000504", pc_addr, new_addr); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h504)
      $display("FAIL ar_first_req: got req %0b addr %h want 1 00000504", imem_req, imem_addr); else n_pass++;
    @(negedge clk);
    #1; @(negedge clk);
    #1;
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h504 || if_instr !== mem_f(32'h504))
      $display("FAIL ar_refetch: got v %0b pc %h instr %h want 1 00000504 %h", if_valid, if_pc, if_instr, mem_f(32'h504));
    else n_pass++;
    @(negedge clk);
  endtask

  // Decode must see the program stream: each delivery is the previous PC + 4,
  // except that a taken branch makes the next delivery its target.
  task automatic test_random(input int n_cycles);
    logic [31:0] exp_pc;
    logic [31:0] start;
    int          delivered, idle;
    mem_lat_min = 1; mem_lat_max = 3;
    start = $urandom & 32'hFFFF_FFFC;
    do_reset(start);
    exp_pc = start;
    delivered = 0; idle = 0;
    for (int i = 0; i < n_cycles; i++) begin
      id_ready  = ($urandom_range(9, 0) < 7);
      br_taken  = ($urandom_range(19, 0) == 0);
      br_target = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      #1;
      if (imem_req) begin
        n_checks++;
        if (imem_addr !== pc_addr || mem_busy)
          $display("FAIL rnd_req: got addr %h busy %0b want %h 0", imem_addr, mem_busy, pc_addr);
        else n_pass++;
      end
      if (if_valid && id_ready) begin
        n_checks++;
        if (if_pc !== exp_pc || if_instr !== mem_f(exp_pc))
          $display("FAIL rnd_deliver: got pc %h instr %h want %h %h", if_pc, if_instr, exp_pc, mem_f(exp_pc));
        else n_pass++;
        exp_pc = exp_pc + 32'd4;
        delivered++;
        idle = 0;
      end else begin
        idle++;
      end
      if (br_taken) exp_pc = br_target;
      if (idle > 60) begin
        n_checks++;
        $display("FAIL rnd_stall: got %0d idle cycles want <= 60", idle);
        break;
      end
      @(negedge clk);
    end
    br_taken = 1'b0;
    id_ready = 1'b0;
    n_checks++;
    if (delivered < n_cycles / 10) $display("FAIL rnd_throughput: got %0d deliveries want >= %0d", delivered, n_cycles / 10);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_branch_wait();
    test_branch_coincident();
    test_wrap();
    test_async_reset();
    test_random(3000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- Fetch stage that sits between the program counter and decode.
- Each cycle it consumes the current PC (pc_addr) and drives the PC's next-address input (new_addr); the PC register updates every clk posedge.
- It issues one instruction-memory request at a time and buffers the returned instruction in an IF/ID output register with a valid/ready handshake to decode.
- It redirects on a taken branch and flushes anything already fetched.

Parameters:
- XLEN, 32, address/instruction width.
- PC_INC, 4, byte increment for a sequential fetch.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- pc_addr  input  XLEN  current PC value from the program counter.
- new_addr  output  XLEN  next PC value, combinational, sampled by the PC every posedge.
- imem_req  output  1  instruction-memory request strobe; one-cycle pulse.
- imem_addr  output  XLEN  request address; equals pc_addr while imem_req=1.
- imem_valid  input  1  response valid; latency ≥1 cycle after imem_req.
- imem_rdata  input  XLEN  response instruction; valid when imem_valid=1.
- br_taken  input  1  branch/jump redirect from execute.
- br_target  input  XLEN  redirect address.
- if_valid  output  1  IF/ID register holds a valid instruction.
- if_instr  output  XLEN  IF/ID instruction.
- if_pc  output  XLEN  PC of if_instr.
- id_ready  input  1  decode accepts IF/ID this cycle; transfer when if_valid&id_ready.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=S_REQ.
  - if_valid=0, if_instr=0, if_pc=0, pending buffer cleared.
  - imem_req=0 while in reset.
  - new_addr=pc_addr (PC held).
- new_addr priority, combinational:
  - br_taken → br_target.
  - else advance → pc_addr+PC_INC, modulo 2^XLEN (0xFFFFFFFC+4 wraps to 0).
  - else pc_addr.
- advance: asserted in the cycle an instruction for pc_addr is written into IF/ID, either directly or from the pending buffer.
- out_free = !if_valid | id_ready.
- States:
  - S_REQ:
    - imem_req=1, imem_addr=pc_addr; go to S_WAIT.
    - If br_taken, imem_req is still issued; go to S_DROP instead.
  - S_WAIT:
    - imem_req=0.
    - On imem_valid & !br_taken:
      - If out_free: IF/ID ← {imem_rdata, pc_addr}, if_valid=1, advance, go to S_REQ.
      - Else: pending ← {imem_rdata, pc_addr}, go to S_HOLD (no advance).
    - On br_taken without imem_valid: go to S_DROP.
    - On br_taken with imem_valid: discard the response, go to S_REQ.
  - S_HOLD:
    - When id_ready & !br_taken: IF/ID ← pending, advance, go to S_REQ.
    - br_taken: discard pending, go to S_REQ.
  - S_DROP:
    - Wait for imem_valid, discard it, go to S_REQ.
    - Further br_taken here only updates new_addr.
- IF/ID register:
  - If a transfer happens with no new write, if_valid←0.
  - br_taken in any state clears if_valid at the next edge. Flush wins over a simultaneous id_ready; the decode transfer that cycle is still counted as taken by decode.
- Ordering and throughput:
  - At most one outstanding imem request.
  - Instructions reach IF/ID in program order.
  - Peak throughput is 1 instruction per 2 cycles at 1-cycle memory latency.
- Reset mid-request: the in-flight response after rst_n deasserts is not tracked; memory must cancel on reset.

Test Plan:
- Sequential fetch: pc_addr=0x00, memory latency 1, id_ready=1.
  - Required: imem_req pulses at addr 0x00, 0x04, 0x08.
  - if_instr/if_pc sequence matches, with new_addr=pc+4 on each capture cycle.
- Backpressure: id_ready=0 while if_valid=1 and the next response arrives.
  - Required: state S_HOLD, new_addr=pc_addr, if_instr unchanged.
  - On raising id_ready, IF/ID ← pending and new_addr=pc+4 that cycle.
- Branch in S_WAIT: br_taken=1, br_target=0x100 before the response arrives.
  - Required: new_addr=0x100, if_valid=0 next cycle.
  - The late imem_valid is dropped; the next imem_addr is 0x100.
- Branch coincident with imem_valid.
  - Required: response discarded, if_valid=0, next request at br_target.
- Wrap-around: pc_addr=0xFFFFFFFC.
  - Required: new_addr=0x00000000 on capture.
- Async reset asserted mid-S_HOLD, between clock edges.
  - Required: if_valid=0 and imem_req=0 immediately.
  - After release, the first request is at the current pc_addr.
